// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter between the CPU datapath and a host load/debug port.
// Round-robin on conflict, 1-cycle read latency, and a halt FSM that freezes CPU traffic.
module data_mem_arbiter #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_write,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_halt,
    output logic              halted,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);

    typedef enum logic [1:0] {
        StRun,
        StHaltReq,
        StHalted
    } state_e;

    state_e            state_q, state_d;
    logic              last_host_q, last_host_d;
    logic              cpu_pend_q, cpu_pend_d;
    logic              host_pend_q, host_pend_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              cpu_gnt;
    logic              host_gnt_w;

    // Grants are forced low while reset is asserted so no stray strobe reaches memory.
    always_comb begin
        cpu_gnt    = 1'b0;
        host_gnt_w = 1'b0;
        if (reset) begin
            if (state_q == StRun) begin
                if (cpu_req && host_req) begin
                    cpu_gnt    = last_host_q;
                    host_gnt_w = ~last_host_q;
                end else begin
                    cpu_gnt    = cpu_req;
                    host_gnt_w = host_req;
                end
            end else begin
                host_gnt_w = host_req;
            end
        end
    end

    always_comb begin
        last_host_d  = last_host_q;
        if (cpu_gnt) begin
            last_host_d = 1'b0;
        end else if (host_gnt_w) begin
            last_host_d = 1'b1;
        end
        cpu_pend_d   = cpu_gnt & ~cpu_write;
        host_pend_d  = host_gnt_w & ~host_write;
        cpu_rdata_d  = cpu_pend_q ? mem_data_out : cpu_rdata_q;
        host_rdata_d = host_pend_q ? mem_data_out : host_rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StRun;
            last_host_q  <= 1'b1;
            cpu_pend_q   <= 1'b0;
            host_pend_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            last_host_q  <= last_host_d;
            cpu_pend_q   <= cpu_pend_d;
            host_pend_q  <= host_pend_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    // HALT_REQ waits until no CPU read is left in flight before reporting halted.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (host_halt) state_d = StHaltReq;
            end
            StHaltReq: begin
                if (!host_halt) begin
                    state_d = StRun;
                end else if (!cpu_pend_d) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (!host_halt) state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_comb begin
        cpu_stall   = cpu_req & ~cpu_gnt & reset;
        host_gnt    = host_gnt_w;
        mem_read    = (cpu_gnt & ~cpu_write) | (host_gnt_w & ~host_write);
        mem_write   = (cpu_gnt & cpu_write) | (host_gnt_w & host_write);
        mem_addr    = '0;
        mem_data_in = '0;
        if (cpu_gnt) begin
            mem_addr    = cpu_addr;
            mem_data_in = cpu_wdata;
        end else if (host_gnt_w) begin
            mem_addr    = host_addr;
            mem_data_in = host_wdata;
        end
        cpu_rvalid  = cpu_pend_q;
        host_rvalid = host_pend_q;
        cpu_rdata   = cpu_rdata_d;
        host_rdata  = host_rdata_d;
        halted      = (state_q == StHalted);
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: directed vector table, a reset-abort sequence,
// and randomized traffic compared against a shadow-memory reference model.
module tb_data_mem_arbiter;

    typedef struct packed {
        logic       cr;
        logic       cw;
        logic [5:0] ca;
        logic [7:0] cd;
        logic       hr;
        logic       hw;
        logic [5:0] ha;
        logic [7:0] hd;
        logic       hh;
    } in_t;

    typedef struct packed {
        logic       stall;
        logic       crv;
        logic [7:0] crd;
        logic       hg;
        logic       hrv;
        logic [7:0] hrd;
        logic       halted;
        logic       mr;
        logic       mw;
        logic [5:0] ma;
        logic [7:0] md;
    } out_t;

    typedef struct {
        bit   pre_rst;
        in_t  in;
        out_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cpu_req, cpu_write, host_req, host_write, host_halt;
    logic [5:0] cpu_addr, host_addr;
    logic [7:0] cpu_wdata, host_wdata;
    logic       cpu_stall, cpu_rvalid, host_gnt, host_rvalid, halted;
    logic [7:0] cpu_rdata, host_rdata;
    logic       mem_read, mem_write;
    logic [5:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out = 8'h00;

    int checks = 0;
    int failures = 0;

    data_mem_arbiter #(.ADDR_W(6), .DATA_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .cpu_write    (cpu_write),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_stall    (cpu_stall),
        .cpu_rvalid   (cpu_rvalid),
        .cpu_rdata    (cpu_rdata),
        .host_req     (host_req),
        .host_write   (host_write),
        .host_addr    (host_addr),
        .host_wdata   (host_wdata),
        .host_gnt     (host_gnt),
        .host_rvalid  (host_rvalid),
        .host_rdata   (host_rdata),
        .host_halt    (host_halt),
        .halted       (halted),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory; preload pattern is addr ^ 0xA0.
    logic [7:0] tb_mem [64];
    bit mem_reinit = 1'b1;
    always @(posedge clk) begin
        if (mem_reinit) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= 8'(i) ^ 8'hA0;
        end else if (mem_write) begin
            tb_mem[mem_addr] <= mem_data_in;
        end
        if (mem_read) mem_data_out <= tb_mem[mem_addr];
    end

    // Reference model state
    logic [7:0] shadow [64];
    bit         m_last_host;
    bit         m_cpu_pend, m_host_pend;
    logic [7:0] m_cpu_exp, m_host_exp, m_cpu_rd, m_host_rd;
    bit   [1:0] halt_hist;

    vec_t vecs[$];

    function automatic in_t ci(bit cr, bit cw, logic [5:0] ca, logic [7:0] cd,
                               bit hr, bit hw, logic [5:0] ha, logic [7:0] hd, bit hh);
        in_t r;
        r.cr = cr; r.cw = cw; r.ca = ca; r.cd = cd;
        r.hr = hr; r.hw = hw; r.ha = ha; r.hd = hd; r.hh = hh;
        return r;
    endfunction

    function automatic out_t co(bit stall, bit crv, logic [7:0] crd, bit hg, bit hrv,
                                logic [7:0] hrd, bit hlt, bit mr, bit mw, logic [5:0] ma,
                                logic [7:0] md);
        out_t r;
        r.stall = stall; r.crv = crv; r.crd = crd; r.hg = hg; r.hrv = hrv; r.hrd = hrd;
        r.halted = hlt; r.mr = mr; r.mw = mw; r.ma = ma; r.md = md;
        return r;
    endfunction

    function automatic void add(bit pr, in_t i, out_t o);
        vec_t v;
        v.pre_rst = pr;
        v.in      = i;
        v.exp     = o;
        vecs.push_back(v);
    endfunction

    task automatic drive(input in_t v);
        cpu_req = v.cr; cpu_write = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
        host_req = v.hr; host_write = v.hw; host_addr = v.ha; host_wdata = v.hd;
        host_halt = v.hh;
    endtask

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = co(cpu_stall, cpu_rvalid, cpu_rdata, host_gnt, host_rvalid, host_rdata, halted,
                 mem_read, mem_write, mem_addr, mem_data_in);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h (fields stall,crv,crd,hg,hrv,hrd,halted,mr,mw,ma,md)",
                     name, act, exp);
        end
    endtask

    task automatic model_reset(input bit reinit);
        m_last_host = 1'b1;
        m_cpu_pend  = 1'b0;
        m_host_pend = 1'b0;
        m_cpu_rd    = 8'h00;
        m_host_rd   = 8'h00;
        m_cpu_exp   = 8'h00;
        m_host_exp  = 8'h00;
        halt_hist   = 2'b00;
        if (reinit) for (int i = 0; i < 64; i++) shadow[i] = 8'(i) ^ 8'hA0;
    endtask

    // CPU is frozen exactly when halt was sampled high at the previous edge; halted once
    // halt has been seen at the two previous edges (one HALT_REQ cycle, then HALTED).
    task automatic predict(input in_t v, output out_t o, output bit cg, output bit hg);
        bit frozen;
        frozen = halt_hist[0];
        if (frozen) begin
            cg = 1'b0;
            hg = v.hr;
        end else if (v.cr && v.hr) begin
            cg = m_last_host;
            hg = !m_last_host;
        end else begin
            cg = v.cr;
            hg = v.hr;
        end
        o.stall  = v.cr && !cg;
        o.hg     = hg;
        o.crv    = m_cpu_pend;
        o.crd    = m_cpu_pend ? m_cpu_exp : m_cpu_rd;
        o.hrv    = m_host_pend;
        o.hrd    = m_host_pend ? m_host_exp : m_host_rd;
        o.halted = halt_hist[0] && halt_hist[1];
        o.mr     = (cg && !v.cw) || (hg && !v.hw);
        o.mw     = (cg && v.cw) || (hg && v.hw);
        o.ma     = cg ? v.ca : (hg ? v.ha : 6'h00);
        o.md     = cg ? v.cd : (hg ? v.hd : 8'h00);
    endtask

    task automatic advance(input in_t v, input bit cg, input bit hg);
        if (m_cpu_pend) m_cpu_rd = m_cpu_exp;
        if (m_host_pend) m_host_rd = m_host_exp;
        m_cpu_pend  = cg && !v.cw;
        m_host_pend = hg && !v.hw;
        if (m_cpu_pend) m_cpu_exp = shadow[v.ca];
        if (m_host_pend) m_host_exp = shadow[v.ha];
        if (cg && v.cw) shadow[v.ca] = v.cd;
        if (hg && v.hw) shadow[v.ha] = v.hd;
        if (cg) m_last_host = 1'b0;
        else if (hg) m_last_host = 1'b1;
        halt_hist = {halt_hist[0], v.hh};
    endtask

    task automatic do_reset(input bit reinit);
        drive(ci(0, 0, 0, 0, 0, 0, 0, 0, 0));
        reset = 1'b0;
        if (reinit) mem_reinit = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        mem_reinit = 1'b0;
        reset = 1'b1;
        model_reset(reinit);
    endtask

    initial begin
        in_t  idle, v;
        out_t zero, exp_o;
        bit   cg, hg, hh;

        idle = ci(0, 0, 0, 0, 0, 0, 0, 0, 0);
        zero = co(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);

        // Same-address conflict right after reset: CPU wins, reads old value
        add(1, idle, zero);
        add(0, ci(1, 0, 6'h10, 0, 1, 1, 6'h10, 8'h77, 0), co(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'h10, 0));
        add(0, ci(0, 0, 0, 0, 1, 1, 6'h10, 8'h77, 0),
            co(0, 1, 8'hB0, 1, 0, 0, 0, 0, 1, 6'h10, 8'h77));
        add(0, ci(1, 0, 6'h10, 0, 0, 0, 0, 0, 0), co(0, 0, 8'hB0, 0, 0, 0, 0, 1, 0, 6'h10, 0));
        add(0, idle, co(0, 1, 8'h77, 0, 0, 0, 0, 0, 0, 0, 0));
        // Plain CPU read with 1-cycle latency and data hold
        add(1, ci(1, 0, 6'h05, 0, 0, 0, 0, 0, 0), co(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'h05, 0));
        add(0, idle, co(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0));
        add(0, idle, co(0, 0, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0));
        // Held conflict alternates CPU, HOST, CPU
        v = ci(1, 0, 6'h05, 0, 1, 1, 6'h10, 8'h3C, 0);
        add(1, v, co(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'h05, 0));
        add(0, v, co(1, 1, 8'hA5, 1, 0, 0, 0, 0, 1, 6'h10, 8'h3C));
        add(0, v, co(0, 0, 8'hA5, 0, 0, 0, 0, 1, 0, 6'h05, 0));
        add(0, idle, co(0, 1, 8'hA5, 0, 0, 0, 0, 0, 0, 0, 0));
        // Halt with a CPU read in flight, host writes while frozen, then release
        add(1, ci(1, 0, 6'h05, 0, 0, 0, 0, 0, 1), co(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'h05, 0));
        v = ci(1, 0, 6'h05, 0, 1, 1, 6'h20, 8'h55, 1);
        add(0, v, co(1, 1, 8'hA5, 1, 0, 0, 0, 0, 1, 6'h20, 8'h55));
        add(0, v, co(1, 0, 8'hA5, 1, 0, 0, 1, 0, 1, 6'h20, 8'h55));
        v = ci(1, 0, 6'h05, 0, 1, 1, 6'h20, 8'h55, 0);
        add(0, v, co(1, 0, 8'hA5, 1, 0, 0, 1, 0, 1, 6'h20, 8'h55));
        add(0, v, co(0, 0, 8'hA5, 0, 0, 0, 0, 1, 0, 6'h05, 0));
        add(0, ci(0, 0, 0, 0, 1, 0, 6'h20, 0, 0), co(0, 1, 8'hA5, 1, 0, 0, 0, 1, 0, 6'h20, 0));
        add(0, idle, co(0, 0, 8'hA5, 0, 1, 8'h55, 0, 0, 0, 0, 0));
        add(0, idle, co(0, 0, 8'hA5, 0, 0, 8'h55, 0, 0, 0, 0, 0));

        do_reset(1);
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pre_rst) do_reset(0);
            drive(vecs[i].in);
            #4;
            check($sformatf("vec%0d", i), vecs[i].exp);
            @(posedge clk);
            #1;
        end

        // Reset asserted while a CPU read is outstanding: no rvalid, rdata cleared
        do_reset(0);
        drive(ci(1, 0, 6'h05, 0, 0, 0, 0, 0, 0));
        #4 check("abort_grant", co(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'h05, 0));
        @(posedge clk); #1;
        reset = 1'b0;
        #4 check("abort_in_reset", zero);
        @(posedge clk); #1;
        drive(idle);
        reset = 1'b1;
        #4 check("abort_released", zero);
        @(posedge clk); #1;
        #4 check("abort_no_late_rvalid", zero);
        @(posedge clk); #1;
        drive(ci(1, 0, 6'h10, 0, 1, 1, 6'h10, 8'h77, 0));
        #4 check("abort_first_conflict_cpu", co(0, 0, 0, 0, 0, 0, 0, 1, 0, 6'h10, 0));
        @(posedge clk); #1;

        // Randomized traffic against the reference model
        do_reset(1);
        hh = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) hh = !hh;
            v = ci($urandom_range(0, 1), $urandom_range(0, 1), 6'($urandom_range(0, 7)),
                   8'($urandom), $urandom_range(0, 1), $urandom_range(0, 1),
                   6'($urandom_range(0, 7)), 8'($urandom), hh);
            drive(v);
            predict(v, exp_o, cg, hg);
            #4 check($sformatf("rand%0d", n), exp_o);
            @(posedge clk);
            advance(v, cg, hg);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
Shares the single-port data memory (6-bit address, 8-bit data) between the CPU datapath and an external host port used for program/data loading and debug. It issues at most one access per cycle, uses round-robin on conflict, and stalls the losing CPU access. A halt state machine lets the host freeze CPU memory traffic safely before bulk loading.

Parameters:
ADDR_W, 6, data memory address width
DATA_W, 8, data memory word width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU requests access this cycle
cpu_write  input  1  1 = write, 0 = read
cpu_addr  input  ADDR_W  CPU address
cpu_wdata  input  DATA_W  CPU write data
cpu_stall  output  1  CPU request not granted; hold PC and request
cpu_rvalid  output  1  CPU read data valid
cpu_rdata  output  DATA_W  CPU read data
host_req  input  1  host requests access
host_write  input  1  1 = write, 0 = read
host_addr  input  ADDR_W  host address
host_wdata  input  DATA_W  host write data
host_gnt  output  1  host access issued this cycle
host_rvalid  output  1  host read data valid
host_rdata  output  DATA_W  host read data
host_halt  input  1  host requests CPU memory freeze
halted  output  1  CPU frozen and no CPU read outstanding
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
mem_addr  output  ADDR_W  memory address
mem_data_in  output  DATA_W  memory write data
mem_data_out  input  DATA_W  memory read data, valid the cycle after mem_read

Behaviour:
- Reset (reset=0, async): state=RUN; last_owner=HOST; pending-read flags=0; cpu_rdata=host_rdata=0; cpu_rvalid=host_rvalid=halted=0. Grant-derived outputs (host_gnt, cpu_stall, mem_*) are combinational and read 0 while reset is low.
- Grant logic is combinational, from requests, state and last_owner:
  - RUN: if only one requester is active, it wins. If both are active, the one that is not last_owner wins.
  - HALT_REQ / HALTED: CPU is never granted; host wins whenever host_req=1.
- Granted access drives mem_read/mem_write, mem_addr and mem_data_in from the winner in the same cycle. With no grant, all mem_* outputs are 0.
- Only one of mem_read/mem_write is high in any cycle.
- cpu_stall = cpu_req & ~cpu_granted. host_gnt = host granted.
- last_owner updates at the clock edge to the winner of any granted cycle. It is unchanged in idle cycles.
- Read latency is 1:
  - A read granted in cycle T sets the owner's pending flag.
  - In T+1: owner rvalid=1, owner rdata = mem_data_out (routed through), and the value is captured.
  - Outside rvalid cycles, rdata holds the last captured value.
- Writes produce no rvalid.
- Back-to-back reads to either owner are allowed every cycle.
- Halt FSM:
  - RUN→HALT_REQ: when host_halt=1.
  - HALT_REQ→HALTED: when no CPU read is pending, i.e. the next edge after a T+1 rvalid or immediately.
  - HALTED: halted=1.
  - HALT_REQ or HALTED→RUN: when host_halt=0.
- Reset mid-access: pending flags are cleared, so no rvalid is ever produced for the aborted read.
- Same-address CPU/host conflict: serialised by arbitration. The later grant sees the earlier write.

Test Plan:
- Reset then idle → all outputs 0, halted=0. First conflict after reset goes to CPU.
- CPU read addr 0x05, memory returns 0xA5 → T: mem_read=1, mem_addr=0x05, cpu_stall=0. T+1: cpu_rvalid=1, cpu_rdata=0xA5. T+2: cpu_rvalid=0, cpu_rdata stays 0xA5.
- cpu_req and host_req (host write 0x3C→addr 0x10) held 3 cycles → winners CPU, HOST, CPU. cpu_stall=0,1,0. host_gnt=0,1,0. mem_write=1 with mem_data_in=0x3C only in cycle 2.
- CPU read granted in T, host_halt=1 in T → cpu_rvalid=1 in T+1, halted=1 from T+2. cpu_req held → cpu_stall=1 throughout. Host writes granted every cycle. Dropping host_halt → RUN, CPU granted next cycle.
- CPU read granted in T, reset low in T+1 → cpu_rvalid stays 0. After release: state RUN, cpu_rdata=0.
- Same cycle after reset: CPU reads addr 0x10, host writes 0x77 to 0x10 → CPU wins and reads the old value. Host is granted next cycle. A subsequent CPU read of 0x10 returns 0x77.
